// File: rtl/simple_compute_top.sv
// simple_compute_top: two ap_ctrl_hs kernels, sum of squares (kernel 0) and an arithmetic series seeded with result0 (kernel 1).
// Optional macro SIMPLE_COMPUTE_IDLE_EN adds ap_idle0/ap_idle1 status outputs.

module simple_compute_kernel #(
    parameter int N     = 8,
    parameter int WIDTH = 32,
    parameter int KIND  = 0
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_start,
    input  logic [WIDTH-1:0] seed,
    output logic             ap_ready,
    output logic             ap_done,
`ifdef SIMPLE_COMPUTE_IDLE_EN
    output logic             ap_idle,
`endif
    output logic [WIDTH-1:0] result
);
    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [7:0] LAST_IDX = 8'(N - 1);

    state_t           state_r, state_s;
    logic [7:0]       idx_r, idx_s;
    logic [WIDTH-1:0] acc_r, acc_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic             ready_r, ready_s;
    logic             done_r, done_s;
    logic [15:0]      sq_s;
    logic [WIDTH-1:0] term_s;
`ifdef SIMPLE_COMPUTE_IDLE_EN
    logic             idle_r;
`endif

    // Per-iteration addend: idx squared (kernel 0) or idx itself (kernel 1)
    always_comb begin
        sq_s = {8'd0, idx_r} * {8'd0, idx_r};
        if (KIND == 0) begin
            term_s = WIDTH'(sq_s);
        end else begin
            term_s = WIDTH'(idx_r);
        end
    end

    // Next-state and registered-output values
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        acc_s    = acc_r;
        result_s = result_r;
        ready_s  = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (ap_start) begin
                    state_s = RUN;
                    idx_s   = 8'd0;
                    acc_s   = seed;
                    ready_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                acc_s = acc_r + term_s;
                idx_s = idx_r + 8'd1;
                if (idx_r == LAST_IDX) begin
                    result_s = acc_r + term_s;
                    done_s   = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge ap_clk) begin
        if (!ap_rst) begin
            state_r  <= IDLE;
            idx_r    <= 8'd0;
            acc_r    <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            ready_r  <= 1'b0;
            done_r   <= 1'b0;
`ifdef SIMPLE_COMPUTE_IDLE_EN
            idle_r   <= 1'b1;
`endif
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            acc_r    <= acc_s;
            result_r <= result_s;
            ready_r  <= ready_s;
            done_r   <= done_s;
`ifdef SIMPLE_COMPUTE_IDLE_EN
            idle_r   <= (state_s == IDLE);
`endif
        end
    end

    assign ap_ready = ready_r;
    assign ap_done  = done_r;
    assign result   = result_r;
`ifdef SIMPLE_COMPUTE_IDLE_EN
    assign ap_idle  = idle_r;
`endif
endmodule

module simple_compute_top #(
    parameter int N     = 8,
    parameter int WIDTH = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_start0,
    output logic             ap_ready0,
    output logic             ap_done0,
    output logic [WIDTH-1:0] result0,
`ifdef SIMPLE_COMPUTE_IDLE_EN
    output logic             ap_idle0,
    output logic             ap_idle1,
`endif
    input  logic             ap_start1,
    output logic             ap_ready1,
    output logic             ap_done1,
    output logic [WIDTH-1:0] result1
);
    // Kernel 0 starts from zero; kernel 1 starts from the registered result0
    simple_compute_kernel #(.N(N), .WIDTH(WIDTH), .KIND(0)) u_k0 (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start0),
        .seed     ({WIDTH{1'b0}}),
        .ap_ready (ap_ready0),
        .ap_done  (ap_done0),
`ifdef SIMPLE_COMPUTE_IDLE_EN
        .ap_idle  (ap_idle0),
`endif
        .result   (result0)
    );

    simple_compute_kernel #(.N(N), .WIDTH(WIDTH), .KIND(1)) u_k1 (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start1),
        .seed     (result0),
        .ap_ready (ap_ready1),
        .ap_done  (ap_done1),
`ifdef SIMPLE_COMPUTE_IDLE_EN
        .ap_idle  (ap_idle1),
`endif
        .result   (result1)
    );
endmodule

// File: tb/tb_simple_compute_top.sv
// Self-checking bench for simple_compute_top: directed handshake scenarios, then random start/reset
// traffic checked against a transaction-level model.
module tb_simple_compute_top;
    localparam int N = 8;
    localparam int W = 32;

    logic         ap_clk = 1'b0;
    logic         ap_rst, ap_start0, ap_start1;
    logic         ap_ready0, ap_done0, ap_ready1, ap_done1;
    logic [W-1:0] result0, result1;
`ifdef SIMPLE_COMPUTE_IDLE_EN
    logic         ap_idle0, ap_idle1;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Transaction-level model state for the random phase
    int           cyc;
    int           free_at [2];
    int           done_at [2];
    logic [W-1:0] pend    [2];
    logic [W-1:0] mres    [2];

    simple_compute_top #(.N(N), .WIDTH(W)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ap_start0 (ap_start0),
        .ap_ready0 (ap_ready0),
        .ap_done0  (ap_done0),
        .result0   (result0),
`ifdef SIMPLE_COMPUTE_IDLE_EN
        .ap_idle0  (ap_idle0),
        .ap_idle1  (ap_idle1),
`endif
        .ap_start1 (ap_start1),
        .ap_ready1 (ap_ready1),
        .ap_done1  (ap_done1),
        .result1   (result1)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic logic [W-1:0] sum_sq(input int n);
        logic [W-1:0] s = 32'd0;
        for (int i = 0; i < n; i++) s += W'(i * i);
        return s;
    endfunction

    function automatic logic [W-1:0] series(input int n);
        return W'(n * (n - 1) / 2);
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic rstep(input bit rst, input bit s0, input bit s1);
        bit           st [2];
        bit           erdy [2];
        bit           edn [2];
        logic [W-1:0] old0;
        st[0] = s0;
        st[1] = s1;
        ap_rst    = rst ? 1'b0 : 1'b1;
        ap_start0 = s0;
        ap_start1 = s1;
        tick();
        cyc++;
        old0 = mres[0];
        for (int k = 0; k < 2; k++) begin
            erdy[k] = 1'b0;
            edn[k]  = 1'b0;
            if (rst) begin
                mres[k]    = 32'd0;
                free_at[k] = cyc + 1;
                done_at[k] = -1;
            end else begin
                if (cyc == done_at[k]) begin
                    edn[k]     = 1'b1;
                    mres[k]    = pend[k];
                    done_at[k] = -1;
                end
                if (st[k] && cyc >= free_at[k]) begin
                    erdy[k]    = 1'b1;
                    done_at[k] = cyc + N;
                    free_at[k] = cyc + N + 1;
                    pend[k]    = (k == 0) ? sum_sq(N) : old0 + series(N);
                end
            end
        end
        chk("rnd_ready0", ap_ready0, erdy[0]);
        chk("rnd_done0",  ap_done0,  edn[0]);
        chk("rnd_result0", result0,  mres[0]);
        chk("rnd_ready1", ap_ready1, erdy[1]);
        chk("rnd_done1",  ap_done1,  edn[1]);
        chk("rnd_result1", result1,  mres[1]);
`ifdef SIMPLE_COMPUTE_IDLE_EN
        chk("rnd_idle0", ap_idle0, done_at[0] < 0);
        chk("rnd_idle1", ap_idle1, done_at[1] < 0);
`endif
    endtask

    initial begin
        ap_rst    = 1'b0;
        ap_start0 = 1'b0;
        ap_start1 = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_ready0", ap_ready0, 0);
        chk("rst_done0",  ap_done0,  0);
        chk("rst_ready1", ap_ready1, 0);
        chk("rst_done1",  ap_done1,  0);
        chk("rst_result0", result0,  0);
        chk("rst_result1", result1,  0);
`ifdef SIMPLE_COMPUTE_IDLE_EN
        chk("rst_idle0", ap_idle0, 1);
        chk("rst_idle1", ap_idle1, 1);
`endif
        ap_rst = 1'b1;
        tick();

        // Single kernel 0 run
        ap_start0 = 1'b1;
        tick();
        chk("k0_ready", ap_ready0, 1);
        chk("k0_done_early", ap_done0, 0);
`ifdef SIMPLE_COMPUTE_IDLE_EN
        chk("k0_idle_low", ap_idle0, 0);
`endif
        ap_start0 = 1'b0;
        for (int k = 1; k <= N; k++) begin
            tick();
            chk("k0_done", ap_done0, k == N);
            chk("k0_ready_once", ap_ready0, 0);
            chk("k0_result_t", result0, (k == N) ? sum_sq(N) : 32'd0);
        end
        chk("k0_result", result0, 32'd140);
        tick();
        chk("k0_done_pulse", ap_done0, 0);
        chk("k0_hold", result0, 32'd140);

        // Sequenced kernel 1 run
        ap_start1 = 1'b1;
        tick();
        chk("k1_ready", ap_ready1, 1);
        ap_start1 = 1'b0;
        for (int k = 1; k <= N; k++) begin
            tick();
            chk("k1_done", ap_done1, k == N);
            chk("k1_ready_once", ap_ready1, 0);
        end
        chk("k1_result", result1, 32'd168);

        // Back-to-back kernel 0 runs with start held high
        ap_start0 = 1'b1;
        tick();
        chk("b2b_ready1", ap_ready0, 1);
        for (int k = 1; k <= N; k++) begin
            tick();
            chk("b2b_done1", ap_done0, k == N);
            chk("b2b_start_ignored", ap_ready0, 0);
        end
        tick();
        chk("b2b_ready2", ap_ready0, 1);
        chk("b2b_done_not_ext", ap_done0, 0);
        ap_start0 = 1'b0;
        for (int k = 1; k <= N; k++) begin
            tick();
            chk("b2b_done2", ap_done0, k == N);
            chk("b2b_result_hold", result0, 32'd140);
        end

        // Reset priority over start, then concurrent start from reset
        ap_rst    = 1'b0;
        ap_start0 = 1'b1;
        ap_start1 = 1'b1;
        tick();
        chk("prio_ready0", ap_ready0, 0);
        chk("prio_ready1", ap_ready1, 0);
        chk("prio_result0", result0, 0);
        ap_rst = 1'b1;
        tick();
        chk("conc_ready0", ap_ready0, 1);
        chk("conc_ready1", ap_ready1, 1);
        ap_start0 = 1'b0;
        ap_start1 = 1'b0;
        for (int k = 1; k <= N; k++) begin
            tick();
            chk("conc_done0", ap_done0, k == N);
            chk("conc_done1", ap_done1, k == N);
        end
        chk("conc_result0", result0, 32'd140);
        chk("conc_result1", result1, 32'd28);

        // Mid-run reset aborts kernel 0
        ap_start0 = 1'b1;
        tick();
        chk("mid_ready", ap_ready0, 1);
        ap_start0 = 1'b0;
        repeat (4) tick();
        ap_rst = 1'b0;
        tick();
        chk("mid_done", ap_done0, 0);
        chk("mid_result", result0, 0);
        ap_rst = 1'b1;
        for (int k = 0; k < N + 2; k++) begin
            tick();
            chk("mid_no_done", ap_done0, 0);
        end
        ap_start0 = 1'b1;
        tick();
        chk("mid_restart_ready", ap_ready0, 1);
        ap_start0 = 1'b0;
        for (int k = 1; k <= N; k++) begin
            tick();
            chk("mid_restart_done", ap_done0, k == N);
        end
        chk("mid_restart_result", result0, 32'd140);

        // Random start/reset traffic against the transaction model
        cyc = 0;
        rstep(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            rstep($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/simple_compute_top.md
# simple_compute_top

Two independent, fixed-function compute kernels behind HLS-style `ap_ctrl_hs` block-level handshakes, packaged as one top-level wrapper. Kernel 0 computes a sum of squares and kernel 1 adds an arithmetic series to kernel 0's latest result. The block sits under a controller or testbench that sequences the two kernels through their start/ready/done handshakes.

## Interface
- `N`, default 8: iteration count per kernel run; legal range 1..255.
- `WIDTH`, default 32: result width.
- `ap_clk` in 1: single clock, rising-edge.
- `ap_rst` in 1: reset, synchronous, active-low (0 = reset).
- `ap_start0` in 1: kernel 0 start request (level).
- `ap_ready0` out 1: kernel 0 start accepted; one-cycle pulse.
- `ap_done0` out 1: kernel 0 finished; one-cycle pulse.
- `result0` out WIDTH: kernel 0 result.
- `ap_start1` in 1: kernel 1 start request (level).
- `ap_ready1` out 1: kernel 1 start accepted; one-cycle pulse.
- `ap_done1` out 1: kernel 1 finished; one-cycle pulse.
- `result1` out WIDTH: kernel 1 result.

## Operation
- Each kernel has its own FSM with states IDLE and RUN.
- Both kernels also hold an index register `idx` (8-bit) and an accumulator `acc` (WIDTH).
- IDLE, `ap_start` = 1 at a clock edge (the accept edge):
  - FSM goes to RUN.
  - `idx` is cleared to 0.
  - Kernel 0 clears `acc` to 0.
  - Kernel 1 loads `acc` with the current `result0`.
- IDLE, `ap_start` = 0: FSM stays in IDLE.
- RUN, each edge:
  - Kernel 0: `acc` += `idx`*`idx`.
  - Kernel 1: `acc` += `idx`.
  - Then `idx` += 1.
- On the edge that processes `idx` = N-1:
  - The final sum is written to `result`.
  - FSM returns to IDLE.
- Kernel 0 final value: the sum of i² for i = 0..N-1.
- Kernel 1 final value: `result0` sampled at its accept edge, plus N(N-1)/2.
- Arithmetic is unsigned and wraps modulo 2^WIDTH. The product `idx`*`idx` is zero-extended to WIDTH before the add.
- Kernels are fully independent and may run concurrently.
- `result0` and `result1` hold their value until the next completion of the same kernel.
- Reset, while `ap_rst` = 0 at an edge:
  - Both FSMs go to IDLE.
  - `idx`, `acc`, `result0` and `result1` are cleared to 0.
  - All `ap_ready*` and `ap_done*` outputs are 0.
  - Reset mid-run aborts the run; no `ap_done` is generated.
- `ap_start` asserted during RUN is ignored.

## Timing
- All outputs are registered.
- Let E0 be the accept edge.
  - `ap_ready` is high for exactly the cycle after E0.
  - Run edges are E1..EN.
  - `ap_done` is high for exactly the cycle after EN, and `result` is valid from that same cycle.
  - Start-to-done latency is N cycles.
  - For N = 1, `ap_ready` (after E0) and `ap_done` (after E1) occur in consecutive cycles.
- Back-to-back runs:
  - If `ap_start` is still high at edge EN+1, that edge is a new accept edge.
  - `ap_done` and the new `ap_ready` then occur in consecutive cycles, and `ap_done` is not extended.
- Sampling of `result0` by kernel 1:
  - If kernel 1 accepts on the same edge that kernel 0 writes `result0`, kernel 1 samples the old (pre-edge) `result0`.
  - Kernel 1 samples nothing from kernel 0 after its accept edge.
- Reset has priority over start: `ap_rst` = 0 together with `ap_start` = 1 results in IDLE with `ap_ready` = 0.

## Configuration
- `SIMPLE_COMPUTE_IDLE_EN` defined:
  - Adds outputs `ap_idle0` and `ap_idle1` (1 bit each).
  - Each is high while its FSM is in IDLE, is 1 during and after reset, and goes low in the cycle after the accept edge.
- Undefined: those ports do not exist; all other behaviour is identical.

## Test plan
- Reset, then check outputs: hold `ap_rst` = 0 for 2 cycles → all `ap_ready`/`ap_done` = 0 and `result0` = `result1` = 0 (plus `ap_idle*` = 1 with `SIMPLE_COMPUTE_IDLE_EN`).
- Single kernel 0 run: N = 8, raise `ap_start0`, drop it after `ap_ready0` → `ap_ready0` pulses 1 cycle after accept, `ap_done0` pulses 8 cycles after accept, `result0` = 140.
- Sequenced kernel 1 run: after that run completes, pulse `ap_start1` until `ap_ready1` → `ap_done1` 8 cycles after accept, `result1` = 168.
- Back-to-back: hold `ap_start0` high for two runs → `ap_done0` then `ap_ready0` in consecutive cycles, second `result0` = 140.
- Concurrent start: start both kernels on the same edge from reset → kernel 1 samples `result0` = 0 and gives `result1` = 28; both `ap_done` pulses coincide.
- Mid-run reset: assert `ap_rst` = 0 four cycles after accept → no `ap_done0`, `result0` = 0; a subsequent start completes normally with 140.
